// File: rtl/alu_shifter_pipe_if.sv
// Operand/result handshake bundle between the register-read stage and the
// ALU/shifter pipe; master drives operands and out_ready, slave answers.
interface alu_shifter_pipe_if #(
  parameter int WIDTH = 16
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shift_d;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [3:0]       szcv;

  modport master (
    output in_valid, a, b, shift_d, op, out_ready,
    input  in_ready, out_valid, res, szcv
  );

  modport slave (
    input  in_valid, a, b, shift_d, op, out_ready,
    output in_ready, out_valid, res, szcv
  );
endinterface

// File: rtl/alu_shifter_pipe.sv
// Two-stage ALU/shifter: S1 captures the operation, S2 computes and holds
// res/szcv. Each stage refills when empty or when its content leaves.
module alu_shifter_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_shifter_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  localparam logic [SHW:0] W_AMT = (SHW + 1)'(WIDTH);

  logic             s1_valid_reg;
  logic [3:0]       s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [SHW-1:0]   s1_k_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_res_reg;
  logic [3:0]       s2_szcv_reg;

  logic             s2_load;
  logic             s1_load;

  // S2 may take new content when empty or when the consumer drains it now
  assign s2_load      = !s2_valid_reg || bus.out_ready;
  assign bus.in_ready = !s1_valid_reg || s2_load;
  assign s1_load      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid_reg;
  assign bus.res       = s2_res_reg;
  assign bus.szcv      = s2_szcv_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_k_reg     <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid_reg <= bus.in_valid;
      end
      if (s1_load) begin
        s1_op_reg <= bus.op;
        s1_a_reg  <= bus.a;
        s1_b_reg  <= bus.b;
        s1_k_reg  <= bus.shift_d;
      end
    end
  end

  // Extended-width datapath: the extra bit carries the carry/borrow or the
  // last bit shifted out, so flags fall out of the same adders/shifters.
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH:0]   lsh_c;
  logic [WIDTH:0]   rsh_c;
  logic [WIDTH:0]   sra_c;
  logic [WIDTH-1:0] rot_c;

  assign sum_c  = {1'b0, s1_b_reg} + {1'b0, s1_a_reg};
  assign diff_c = {1'b0, s1_b_reg} - {1'b0, s1_a_reg};
  assign lsh_c  = {1'b0, s1_b_reg} << s1_k_reg;
  assign rsh_c  = {s1_b_reg, 1'b0} >> s1_k_reg;
  assign sra_c  = (WIDTH + 1)'($signed({s1_b_reg, 1'b0}) >>> s1_k_reg);
  // A shift by WIDTH yields zero, so k=0 degenerates to plain b
  assign rot_c  = (s1_b_reg << s1_k_reg) | (s1_b_reg >> (W_AMT - {1'b0, s1_k_reg}));

  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] flag_src_c;
  logic             c_c;
  logic             v_c;
  logic [3:0]       szcv_c;

  always_comb begin
    res_c      = '0;
    flag_src_c = '0;
    c_c        = 1'b0;
    v_c        = 1'b0;
    szcv_c     = 4'b0000;
    case (s1_op_reg)
      OP_ADD: begin
        res_c = sum_c[MSB:0];
        c_c   = sum_c[WIDTH];
        v_c   = (s1_a_reg[MSB] == s1_b_reg[MSB]) && (sum_c[MSB] != s1_b_reg[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res_c = (s1_op_reg == OP_CMP) ? s1_b_reg : diff_c[MSB:0];
        c_c   = diff_c[WIDTH];
        v_c   = (s1_a_reg[MSB] != s1_b_reg[MSB]) && (diff_c[MSB] != s1_b_reg[MSB]);
      end
      OP_AND: res_c = s1_a_reg & s1_b_reg;
      OP_OR:  res_c = s1_a_reg | s1_b_reg;
      OP_XOR: res_c = s1_a_reg ^ s1_b_reg;
      OP_MOV: res_c = s1_a_reg;
      OP_SLL: begin
        res_c = lsh_c[MSB:0];
        c_c   = lsh_c[WIDTH];
      end
      OP_SLR: begin
        res_c = rot_c;
        c_c   = lsh_c[WIDTH];
      end
      OP_SRL: begin
        res_c = rsh_c[WIDTH:1];
        c_c   = rsh_c[0];
      end
      OP_SRA: begin
        res_c = sra_c[WIDTH:1];
        c_c   = sra_c[0];
      end
      default: res_c = '0;
    endcase
    // Compare reports flags of the subtraction while passing b through
    flag_src_c = (s1_op_reg == OP_CMP) ? diff_c[MSB:0] : res_c;
    szcv_c     = {flag_src_c[MSB], (flag_src_c == '0), c_c, v_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_res_reg   <= '0;
      s2_szcv_reg  <= '0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_res_reg  <= res_c;
        s2_szcv_reg <= szcv_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_shifter_pipe.sv
// Scoreboard bench: driver pushes expected results on each input transfer,
// a negedge monitor compares every presented output against the queue head.
module tb_alu_shifter_pipe;
  localparam int W   = 16;
  localparam int SHW = $clog2(W);

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   accept_cnt = 0;
  bit   rand_on;

  logic [W+3:0] exp_q[$];
  int           pop_log[$];

  alu_shifter_pipe_if #(.WIDTH(W)) bus ();

  alu_shifter_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: integer arithmetic straight from the opcode rules
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [SHW-1:0] k);
    longint ua, ub, sa, sb, r, fv, full, lo, hi;
    int kk;
    bit c, v, s, z;
    logic [W-1:0] rr;
    full = longint'(1) << W;
    lo = -(longint'(1) << (W - 1));
    hi = (longint'(1) << (W - 1)) - 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - full : ua;
    sb = b[W-1] ? ub - full : ub;
    kk = int'(k);
    c = 0;
    v = 0;
    r = 0;
    case (op)
      4'h0: begin
        r = ub + ua;
        c = (r >= full);
        v = (sb + sa > hi) || (sb + sa < lo);
      end
      4'h1, 4'h5: begin
        r = ub - ua;
        c = (ub < ua);
        v = (sb - sa > hi) || (sb - sa < lo);
      end
      4'h2: r = ub & ua;
      4'h3: r = ub | ua;
      4'h4: r = ub ^ ua;
      4'h6: r = ua;
      4'h8, 4'h9: begin
        r = (op == 4'h8 || kk == 0) ? (ub << kk) : ((ub << kk) | (ub >> (W - kk)));
        c = (kk != 0) && (((ub >> (W - kk)) & 1) != 0);
      end
      4'hA, 4'hB: begin
        r = (op == 4'hA) ? (ub >> kk) : (sb >>> kk);
        c = (kk != 0) && (((ub >> (kk - 1)) & 1) != 0);
      end
      default: r = 0;
    endcase
    r = r & (full - 1);
    fv = r;
    if (op == 4'h5) r = ub;
    s = ((fv >> (W - 1)) & 1) != 0;
    z = (fv == 0);
    rr = r[W-1:0];
    return {rr, s, z, c, v};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [SHW-1:0] k, input bit use_exp, input logic [W+3:0] exp_v);
    bit ok;
    ok = 0;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.shift_d = k;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (ok) begin
      exp_q.push_back(use_exp ? exp_v : model(op, a, b, k));
      accept_cnt++;
      $display("[TB] issue op=%b a=%h b=%h k=%0d", op, a, b, k);
    end else begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1 within 64 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SHW-1:0] k, input logic [W-1:0] er, input logic [3:0] ef);
    send(op, a, b, k, 1'b1, {er, ef});
  endtask

  task automatic send_rand();
    send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
         SHW'($urandom_range(0, W - 1)), 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every presented output must match the oldest pending result
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: res=%h szcv=%b, expected no output", bus.res, bus.szcv);
      end else begin
        if ({bus.res, bus.szcv} !== exp_q[0]) begin
          fails++;
          $display("FAIL result: res=%h szcv=%b, expected res=%h szcv=%b",
                   bus.res, bus.szcv, exp_q[0][W+3:4], exp_q[0][3:0]);
        end
        if (bus.out_ready) begin
          $display("[TB] result res=%h szcv=%b cycle=%0d", bus.res, bus.szcv, cyc);
          void'(exp_q.pop_front());
          pop_log.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.shift_d = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_res", 64'(bus.res), 64'd0);
    check("rst_szcv", 64'(bus.szcv), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency: result visible after the second edge following transfer
    send_exp(4'b0000, 16'h0001, 16'h7FFF, 4'd0, 16'h8000, 4'b1001);
    check("lat_first_edge", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_second_edge", 64'(bus.out_valid), 64'd1);

    send_exp(4'b0001, 16'h0001, 16'h0000, 4'd0, 16'hFFFF, 4'b1010);
    send_exp(4'b0101, 16'h0005, 16'h0005, 4'd0, 16'h0005, 4'b0100);
    send_exp(4'b1001, 16'h0000, 16'h8001, 4'd1, 16'h0003, 4'b0010);
    send_exp(4'b1011, 16'h0000, 16'h8000, 4'd15, 16'hFFFF, 4'b1000);
    send_exp(4'b1000, 16'h0000, 16'h1234, 4'd0, 16'h1234, 4'b0000);
    send_exp(4'b0000, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 4'b0110);
    send_exp(4'b0111, 16'h1234, 16'h5678, 4'd3, 16'h0000, 4'b0100);
    send_exp(4'b1010, 16'h0000, 16'h0003, 4'd1, 16'h0001, 4'b0010);
    drain();

    // Back-to-back stream must come out gap-free
    pop_log.delete();
    repeat (8) send_rand();
    drain();
    check("stream_count", 64'(pop_log.size()), 64'd8);
    if (pop_log.size() >= 8) check("stream_span", 64'(pop_log[7] - pop_log[0]), 64'd7);

    // Consumer stall: two accepts fill the pipe, then input backpressure
    bus.out_ready = 1'b0;
    base = accept_cnt;
    fork
      repeat (4) send_rand();
      begin
        repeat (5) @(posedge clk);
        #2;
        check("stall_accepts", 64'(accept_cnt - base), 64'd2);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with ops in flight: everything discarded, outputs cleared at once
    repeat (3) send_rand();
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_res", 64'(bus.res), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random gaps and random consumer backpressure
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
